test_sequencer: RTL

TEST_SEQUENCER -- requirements
Module: test_sequencer

---
 rtl/test_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/test_sequencer.sv
// test_sequencer: issues N randomised test vectors, tracks them through a
// LAT-deep in-flight pipe, and compares DUT against reference results.
// Optional feature macro: TEST_SEQ_STOP_ON_FAIL_EN (first mismatch in RUN
// stops issuing; in-flight vectors are still compared).
module test_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned COUNT_W = 16,
  parameter int unsigned LAT     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [COUNT_W-1:0] i_num_tests,
  output logic               o_rand_en,
  output logic               o_issue,
  input  logic [WIDTH-1:0]   i_dut_result,
  input  logic [WIDTH-1:0]   i_ref_result,
  output logic               o_busy,
  output logic               o_done,
  output logic [COUNT_W-1:0] o_pass_count,
  output logic [COUNT_W-1:0] o_fail_count,
  output logic [COUNT_W-1:0] o_first_fail
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [COUNT_W-1:0] ALL_ONES = '1;
  localparam logic [LAT-1:0]     OLD_MASK = LAT'(1) << (LAT - 1);

  state_t             state, next_state;
  logic [COUNT_W-1:0] remaining;
  logic [COUNT_W-1:0] issue_idx;
  logic [LAT-1:0]     pipe_v;
  logic [COUNT_W-1:0] pipe_idx [LAT];
  logic               cmp_v;
  logic               mismatch;
  logic               upstream_busy;

  // Oldest pipe stage is the vector whose results sit at the compare inputs.
  assign cmp_v         = pipe_v[LAT-1];
  assign mismatch      = cmp_v && (i_dut_result != i_ref_result);
  assign upstream_busy = |(pipe_v & ~OLD_MASK);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (i_start) next_state = (i_num_tests != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (remaining == COUNT_W'(1)) next_state = S_DRAIN;
`ifdef TEST_SEQ_STOP_ON_FAIL_EN
        if (mismatch && (o_fail_count == '0)) next_state = S_DRAIN;
`endif
      end
      S_DRAIN: begin
        // Leave once only the oldest stage can still hold a vector.
        if (!upstream_busy) next_state = S_DONE;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Registered control outputs, derived from the upcoming state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      o_rand_en <= 1'b0;
      o_issue   <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_rand_en <= (next_state == S_RUN);
      o_issue   <= (next_state == S_RUN);
      o_busy    <= (next_state != S_IDLE);
      o_done    <= (next_state == S_DONE);
    end
  end

  // In-flight valid/index shift pipe, fed by each issued vector.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pipe_v <= '0;
      for (int i = 0; i < int'(LAT); i++) pipe_idx[i] <= '0;
    end else begin
      for (int i = int'(LAT) - 1; i > 0; i--) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
      pipe_v[0]   <= o_issue;
      pipe_idx[0] <= issue_idx;
    end
  end

  // Run bookkeeping and saturating result counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      remaining    <= '0;
      issue_idx    <= '0;
      o_pass_count <= '0;
      o_fail_count <= '0;
      o_first_fail <= ALL_ONES;
    end else begin
      if (state == S_IDLE && i_start) begin
        remaining    <= i_num_tests;
        issue_idx    <= '0;
        o_pass_count <= '0;
        o_fail_count <= '0;
        o_first_fail <= ALL_ONES;
      end else begin
        if (o_issue) begin
          remaining <= remaining - COUNT_W'(1);
          issue_idx <= issue_idx + COUNT_W'(1);
        end
        if (cmp_v) begin
          if (!mismatch) begin
            if (o_pass_count != ALL_ONES) o_pass_count <= o_pass_count + COUNT_W'(1);
          end else begin
            if (o_fail_count != ALL_ONES) o_fail_count <= o_fail_count + COUNT_W'(1);
            if (o_fail_count == '0)       o_first_fail <= pipe_idx[LAT-1];
          end
        end
      end
    end
  end

endmodule
